// File: rtl/scroll_sched.sv
// scroll_sched: endless-runner game state machine with ground scrolling, speed ramp and score.
module scroll_sched #(
  parameter int GNDW        = 2400,
  parameter int SPD_INIT    = 2,
  parameter int SPD_MAX     = 8,
  parameter int RAMP_FRAMES = 600,
  parameter int DEAD_HOLD   = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_start,
  input  logic        collide,
  output logic [1:0]  gamestate,
  output logic [11:0] gnd_pos,
  output logic [3:0]  speed,
  output logic        step,
  output logic [15:0] score
);
  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, DEAD = 2'b10;
  localparam int RW = $clog2(RAMP_FRAMES + 1);
  localparam int HW = $clog2(DEAD_HOLD + 1);
  logic [1:0] state_q, state_d;
  logic btn_q, armed_q, armed_d, step_q, step_d, press, ramp_end;
  logic [11:0] gnd_q, gnd_d;
  logic [12:0] sum;
  logic [3:0] spd_q, spd_d;
  logic [15:0] score_q, score_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [HW-1:0] hold_q, hold_d;
  // a button held through reset must be seen released before it can count as a press
  always_comb begin
    armed_d = armed_q | ~btn_start;
    press = btn_start & ~btn_q & armed_q;
    sum = {1'b0, gnd_q} + {9'b0, spd_q};
    ramp_end = ramp_q == RW'(RAMP_FRAMES - 1);
    state_d = state_q;
    gnd_d = gnd_q;
    spd_d = spd_q;
    score_d = score_q;
    ramp_d = ramp_q;
    hold_d = hold_q;
    step_d = 1'b0;
    if (state_q == IDLE) begin
      gnd_d = '0;
      spd_d = 4'(SPD_INIT);
      if (press) begin
        state_d = RUN;
        score_d = '0;
        ramp_d = '0;
      end
    end else if (state_q == RUN) begin
      if (collide) begin
        state_d = DEAD;
        hold_d = '0;
      end else if (frame_tick) begin
        step_d = 1'b1;
        gnd_d = 12'(sum >= 13'(GNDW) ? sum - 13'(GNDW) : sum);
        score_d = score_q + 16'(!(&score_q));
        ramp_d = ramp_end ? '0 : ramp_q + RW'(1);
        spd_d = (ramp_end && spd_q < 4'(SPD_MAX)) ? spd_q + 4'd1 : spd_q;
      end
    end else if (state_q == DEAD) begin
      if (frame_tick && hold_q < HW'(DEAD_HOLD)) hold_d = hold_q + HW'(1);
      if (press && hold_q == HW'(DEAD_HOLD)) begin
        state_d = IDLE;
        gnd_d = '0;
        spd_d = 4'(SPD_INIT);
      end
    end else begin
      state_d = IDLE;
      gnd_d = '0;
      spd_d = 4'(SPD_INIT);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      btn_q <= 1'b0;
      armed_q <= 1'b0;
      gnd_q <= '0;
      spd_q <= 4'(SPD_INIT);
      score_q <= '0;
      step_q <= 1'b0;
      ramp_q <= '0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      btn_q <= btn_start;
      armed_q <= armed_d;
      gnd_q <= gnd_d;
      spd_q <= spd_d;
      score_q <= score_d;
      step_q <= step_d;
      ramp_q <= ramp_d;
      hold_q <= hold_d;
    end
  end
  assign gamestate = state_q;
  assign gnd_pos = gnd_q;
  assign speed = spd_q;
  assign step = step_q;
  assign score = score_q;
endmodule

// File: doc/scroll_sched.md
SCROLL_SCHED -- requirements
Module: scroll_sched

Interface
REQ-001 Parameter GNDW, default 2400: ground strip width in pixels; ground offset modulus.
REQ-002 Parameter SPD_INIT, default 2: scroll speed in pixels/frame on entering RUN.
REQ-003 Parameter SPD_MAX, default 8: speed saturation value.
REQ-004 Parameter RAMP_FRAMES, default 600: RUN frames per speed increment.
REQ-005 Parameter DEAD_HOLD, default 60: DEAD frames during which btn_start is ignored.
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 frame_tick  input  1  one-cycle pulse per video frame.
REQ-009 btn_start  input  1  start/restart button, level, synchronous to clk.
REQ-010 collide  input  1  collision flag from sprite logic, level.
REQ-011 gamestate  output  2  00 IDLE, 01 RUN, 10 DEAD; feeds ground drawer and sprite drawers.
REQ-012 gnd_pos  output  12  ground strip read offset, range 0..GNDW-1.
REQ-013 speed  output  4  current scroll speed, pixels/frame.
REQ-014 step  output  1  one-cycle pulse on each cycle gnd_pos advances.
REQ-015 score  output  16  RUN frame count, saturating.

Function
REQ-016 press SHALL be btn_start & ~btn_q, where btn_q is btn_start registered one cycle; only press events cause transitions.
REQ-017 The state machine SHALL have IDLE, RUN and DEAD; encoding 11 SHALL go to IDLE on the next clock.
REQ-018 IDLE -> RUN on press; same edge: gnd_pos=0, speed=SPD_INIT, score=0, ramp counter=0.
REQ-019 RUN -> DEAD on any cycle with collide=1; gnd_pos, speed and score freeze at their current values.
REQ-020 In RUN, if frame_tick=1 and collide=0, gnd_pos SHALL become (gnd_pos+speed) when that sum < GNDW, else (gnd_pos+speed-GNDW), and step SHALL pulse for that cycle only.
REQ-021 The gnd_pos sum SHALL be computed 13 bits wide; gnd_pos SHALL never equal or exceed GNDW.
REQ-022 collide and frame_tick in the same RUN cycle: collide wins; no advance, no step, no score increment.
REQ-023 In RUN, each advancing frame_tick SHALL increment score, saturating at 65535, and the ramp counter.
REQ-024 When the ramp counter reaches RAMP_FRAMES-1 on an advancing tick, it SHALL clear and speed SHALL increment, saturating at SPD_MAX; the new speed applies from the next frame.
REQ-025 On entering DEAD, hold counter=0; each frame_tick in DEAD SHALL increment it, saturating at DEAD_HOLD.
REQ-026 DEAD -> IDLE on press only when hold counter == DEAD_HOLD; earlier presses are ignored.
REQ-027 In IDLE: gnd_pos=0, step=0, speed=SPD_INIT; score holds the last game's value for display.
REQ-028 press in RUN and collide in IDLE SHALL have no effect.
REQ-029 All outputs SHALL be registered; gamestate changes one clock after the triggering input.

Reset
REQ-030 rst=1 SHALL immediately force gamestate=IDLE, gnd_pos=0, speed=SPD_INIT, score=0, step=0, btn_q=0, ramp and hold counters=0, regardless of state, including mid-RUN or mid-DEAD hold.
REQ-031 After rst deasserts, btn_start held high from reset SHALL NOT start a game until released and pressed again.

Verification
REQ-032 Reset, press, 10 frame_ticks, no collide -> gamestate=01, gnd_pos=20, score=10, 10 step pulses.
REQ-033 RUN with gnd_pos=2398, speed=2, frame_tick -> gnd_pos=0; with gnd_pos=2399, speed=8 -> gnd_pos=7.
REQ-034 RUN, 600 ticks -> speed=3 after tick 600; 4200 further ticks -> speed=8 and stays 8.
REQ-035 collide and frame_tick in the same cycle at gnd_pos=100 -> gamestate=10, gnd_pos=100, no step, score unchanged.
REQ-036 DEAD, press after 30 ticks -> stays DEAD; press after 60 ticks -> IDLE, gnd_pos=0; next press -> RUN, score=0.
REQ-037 rst pulsed mid-RUN with btn_start held high -> immediate IDLE with reset values; RUN only after release and re-press.
